// File: rtl/spi_master_arb_pkg.sv
// Package: spi_master_arb_pkg
// Shared types and helpers for the SPI master FIFO-side schedulers.
//   - arb_state_e : arbiter FSM state encoding (ARB_IDLE, ARB_BURST)
//   - *_DEF       : default values for the N_REQ, DATA_WIDTH and LEN_WIDTH parameters
//   - rr_pick()   : rotate-priority search over a request vector of up to MAX_REQ bits.
//                   The search starts at index rr and wraps modulo n_req. It returns
//                   the winner index and a found flag.
package spi_master_arb_pkg;

  localparam int N_REQ_DEF      = 2;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 4;

  // The widest supported requester count. Callers zero-extend narrower vectors to this width.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] rr,
                                       input int unsigned          n_req);
    rr_pick_t    res;
    int unsigned cand;
    res.found = 1'b0;
    res.idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(rr) + k) % n_req;
      if (k < n_req && !res.found && req[cand[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_master_rr_pick.sv
// Module: spi_master_rr_pick
// Purely combinational rotate-priority encoder. Among the set bits of req_i, it picks
// the first one found when searching upward from rr_i, wrapping modulo N_REQ.
// The RX-side scheduler reuses this block.
// Ports:
//   req_i   [N_REQ]  request vector
//   rr_i    [IDX_W]  index with highest priority this cycle
//   idx_o   [IDX_W]  winner index (valid when found_o is high)
//   found_o          at least one request bit is set
module spi_master_rr_pick
  import spi_master_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [MAX_IDX_W-1:0] rr_ext;
  rr_pick_t             pick;

  // NOTE: combinational blocks assign every output a default first, so no path leaves a value held (no latch).
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req_i;
    rr_ext               = '0;
    rr_ext[IDX_W-1:0]    = rr_i;
    pick                 = rr_pick(req_ext, rr_ext, N_REQ);
    idx_o                = pick.idx[IDX_W-1:0];
    found_o              = pick.found;
  end

endmodule

// File: rtl/spi_master_fifo_arbiter.sv
// Module: spi_master_fifo_arbiter
// Round-robin burst arbiter that sits in front of the SPI master TX FIFO input.
// It grants one requester at a time and holds the grant for a whole burst of
// req_len_i+1 words, so bursts from different requesters never interleave.
// The data path is a pure combinational mux selected by the registered grant.
// Optional feature: define SPI_ARB_SPACE_CHECK_EN to grant a burst only when
// the FIFO has room for it, or for the whole FIFO depth if the burst is longer.
// Ports:
//   clk_i, rst_i              clock and synchronous active-high reset
//   abort_i                   abandon the current burst, or block a grant while idle
//   req_i/req_len_i           per-requester burst request and length-1
//   valid_i/data_i/ready_o    per-requester data streams
//   gnt_o                     one-hot registered grant
//   busy_o                    a burst is in progress
//   fifo_valid_o/fifo_data_o/fifo_ready_i   FIFO push port
//   fifo_elements_i           FIFO fill level (used only with SPI_ARB_SPACE_CHECK_EN)
module spi_master_fifo_arbiter
  import spi_master_arb_pkg::*;
#(
  parameter int N_REQ            = N_REQ_DEF,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH        = LEN_WIDTH_DEF,
  parameter int BUFFER_DEPTH     = 8,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        abort_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len_i,
  input  logic [N_REQ-1:0]            valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            ready_o,
  output logic [N_REQ-1:0]            gnt_o,
  output logic                        busy_o,
  output logic                        fifo_valid_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  input  logic                        fifo_ready_i,
  input  logic [LOG_BUFFER_DEPTH:0]   fifo_elements_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e           state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;   // binary copy of the grant; it drives the data mux
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;     // beats left after the current one

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [LEN_WIDTH-1:0] pick_len;
  logic                 beat;
  logic                 space_ok;

  spi_master_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .rr_i    (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign pick_len = req_len_i[pick_idx*LEN_WIDTH +: LEN_WIDTH];

`ifdef SPI_ARB_SPACE_CHECK_EN
  // Grant only if the whole burst fits in the free FIFO space. A burst longer than
  // the FIFO can only wait for an empty FIFO. The round-robin pointer does not move
  // while the winner waits, so a smaller request from another requester cannot jump
  // ahead of it.
  logic [31:0] free_w;
  logic [31:0] need_w;
  assign free_w   = (32'(fifo_elements_i) >= 32'(BUFFER_DEPTH)) ? 32'd0
                  : 32'(BUFFER_DEPTH) - 32'(fifo_elements_i);
  assign need_w   = (32'(pick_len) + 32'd1 > 32'(BUFFER_DEPTH)) ? 32'(BUFFER_DEPTH)
                  : 32'(pick_len) + 32'd1;
  assign space_ok = (free_w >= need_w);
`else
  logic unused_elements;
  assign unused_elements = ^fifo_elements_i;
  assign space_ok        = 1'b1;
`endif

  // Data path: a combinational steer from the registered grant, so no words are stored.
  always_comb begin
    ready_o      = '0;
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    if (state_q == ARB_BURST) begin
      ready_o[gidx_q] = fifo_ready_i;
      fifo_valid_o    = valid_i[gidx_q];
      fifo_data_o     = data_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign beat   = fifo_valid_o && fifo_ready_i;
  assign gnt_o  = gnt_q;
  assign busy_o = (state_q == ARB_BURST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found && !abort_i && space_ok) begin
          state_d         = ARB_BURST;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          gidx_d          = pick_idx;
          cnt_d           = pick_len;
        end
      end
      ARB_BURST: begin
        // Abort has priority. A beat accepted in the same cycle has already gone to
        // the FIFO, and rr stays where it was.
        if (abort_i) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (beat) begin
          if (cnt_q == '0) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            rr_d    = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
